// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB arbiter slice.
//   arb_state_t : slave-side sequencing states (IDLE -> SETUP -> ACCESS).
//   STB_WIDTH   : byte-strobe width of every APB port.
//   idx_width() : index width for a requester count, never narrower than 1 bit.
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam int STB_WIDTH = 4;

  // $clog2(1) is 0, which would produce a zero-width index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at or
// after ptr, wrapping modulo NUM_MASTERS.
//   req     : one request bit per master.
//   ptr     : highest-priority index (must be < NUM_MASTERS).
//   gnt_idx : winning index, 0 when no request is pending.
//   any_req : at least one request is pending.
// -----------------------------------------------------------------------------
module rr_pick
  import apb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   any_req
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop;
    // without it a path that assigns nothing would infer a latch.
    gnt_idx = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    // Walk from the farthest offset down to offset 0 so the candidate closest
    // to ptr is the last one written and therefore wins.
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + SUM_W'(off);
      if (sum >= SUM_W'(NUM_MASTERS)) begin
        sum = sum - SUM_W'(NUM_MASTERS);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        gnt_idx = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Round-robin arbiter sharing one APB slave (the unified sram) between
// NUM_MASTERS APB requesters. The winning request is captured into slave-side
// registers, driven through SETUP and ACCESS, and the completion is routed back
// only to the granted master. A mandatory IDLE cycle separates transfers so the
// sram's ready flag drops before the next penable.
//   pclk, rst      : clock, synchronous active-high reset.
//   m_paddr/m_pdata/m_pstb/m_pwrite : per-master request fields, master i in
//                    slice i of each packed vector.
//   m_psel         : per-master request; m_penable is accepted but unused.
//   m_pready/m_perr: per-master completion and error, one-hot or zero.
//   m_prdata       : shared read data, valid for the master with m_pready set.
//   s_*            : slave-side APB port.
// -----------------------------------------------------------------------------
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MASTERS = 2
) (
  input  logic                              pclk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pdata,
  input  logic [NUM_MASTERS*STB_WIDTH-1:0]  m_pstb,
  input  logic [NUM_MASTERS-1:0]            m_pwrite,
  input  logic [NUM_MASTERS-1:0]            m_psel,
  input  logic [NUM_MASTERS-1:0]            m_penable,
  output logic [NUM_MASTERS-1:0]            m_pready,
  output logic [NUM_MASTERS-1:0]            m_perr,
  output logic [DATA_WIDTH-1:0]             m_prdata,
  output logic [ADDR_WIDTH-1:0]             s_paddr,
  output logic [DATA_WIDTH-1:0]             s_pdata,
  output logic [STB_WIDTH-1:0]              s_pstb,
  output logic                              s_pwrite,
  output logic                              s_psel,
  output logic                              s_penable,
  input  logic                              s_pready,
  input  logic                              s_perr,
  input  logic [DATA_WIDTH-1:0]             s_prdata
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gnt;
  logic [IDX_W-1:0]       gnt_next;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   complete;
  logic [NUM_MASTERS-1:0] grant_oh;

  // Master-side penable carries no timing information here: the arbiter
  // generates its own SETUP/ACCESS phases toward the slave.
  logic unused_penable;
  assign unused_penable = ^m_penable;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req     (m_psel),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // The master just served drops to lowest priority for the next arbitration.
  assign gnt_next = (gnt == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt + IDX_W'(1);

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      s_paddr  <= '0;
      s_pdata  <= '0;
      s_pstb   <= '0;
      s_pwrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            // Capture the winner once; later changes on its inputs are ignored.
            gnt      <= pick_idx;
            s_paddr  <= m_paddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            s_pdata  <= m_pdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            s_pstb   <= m_pstb[int'(pick_idx)*STB_WIDTH +: STB_WIDTH];
            s_pwrite <= m_pwrite[pick_idx];
            state    <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          // No timeout: a slave that never answers holds ACCESS indefinitely.
          if (s_pready) begin
            rr_ptr <= gnt_next;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign s_psel    = (state == SETUP) || (state == ACCESS);
  assign s_penable = (state == ACCESS);

  // Completion is combinational from the slave so the master sees it in the
  // same cycle the sram answers.
  assign complete  = (state == ACCESS) && s_pready;
  assign grant_oh  = NUM_MASTERS'(1) << gnt;
  assign m_pready  = complete ? grant_oh : '0;
  assign m_perr    = (complete && s_perr) ? grant_oh : '0;
  assign m_prdata  = s_prdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
// Self-checking bench for apb_arbiter with two masters. Each issued request
// pushes its expected slave-side fields and response into a per-master queue;
// a monitor pops and compares on every m_pready. Scenario tasks add inline
// cycle-accurate checks on sequencing, arbitration order and reset.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             pclk = 1'b0;
  logic             rst;
  logic [NM*AW-1:0] m_paddr;
  logic [NM*DW-1:0] m_pdata;
  logic [NM*4-1:0]  m_pstb;
  logic [NM-1:0]    m_pwrite;
  logic [NM-1:0]    m_psel;
  logic [NM-1:0]    m_penable;
  logic [NM-1:0]    m_pready;
  logic [NM-1:0]    m_perr;
  logic [DW-1:0]    m_prdata;
  logic [AW-1:0]    s_paddr;
  logic [DW-1:0]    s_pdata;
  logic [3:0]       s_pstb;
  logic             s_pwrite;
  logic             s_psel;
  logic             s_penable;
  logic             s_pready;
  logic             s_perr;
  logic [DW-1:0]    s_prdata;

  apb_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_MASTERS (NM)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .m_paddr   (m_paddr),
    .m_pdata   (m_pdata),
    .m_pstb    (m_pstb),
    .m_pwrite  (m_pwrite),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pready  (m_pready),
    .m_perr    (m_perr),
    .m_prdata  (m_prdata),
    .s_paddr   (s_paddr),
    .s_pdata   (s_pdata),
    .s_pstb    (s_pstb),
    .s_pwrite  (s_pwrite),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pready  (s_pready),
    .s_perr    (s_perr),
    .s_prdata  (s_prdata)
  );

  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------- slave model
  // Answers after `stall` ACCESS cycles; read data and error come from knobs.
  int          stall   = 1;
  int          acc_cnt = 0;
  logic [31:0] rd_val  = '0;
  logic        err_val = 1'b0;

  assign s_pready = s_psel & s_penable & (acc_cnt >= stall);
  assign s_perr   = err_val;
  assign s_prdata = rd_val;

  always @(posedge pclk)
    acc_cnt <= (s_psel && s_penable && !s_pready) ? acc_cnt + 1 : 0;

  // ----------------------------------------------------------------- scoreboard
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  stb;
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[NM][$];
  int   grant_log[$];
  int   total = 0;
  int   bad   = 0;
  int   left[NM];
  int   seq[NM];

  exp_t mon_e;
  int   mon_idx;

  always @(negedge pclk) begin
    if (!rst && m_pready !== '0) begin
      total++;
      if (!$onehot(m_pready) || s_penable !== 1'b1) begin
        bad++;
        $display("FAIL mon_onehot: m_pready=%b s_penable=%b, want one-hot with s_penable=1",
                 m_pready, s_penable);
      end else begin
        mon_idx = 0;
        for (int k = 0; k < NM; k++) if (m_pready[k]) mon_idx = k;
        grant_log.push_back(mon_idx);
        if (exp_q[mon_idx].size() == 0) begin
          bad++;
          $display("FAIL mon_unexpected: m_pready=%b with no pending request", m_pready);
        end else begin
          mon_e = exp_q[mon_idx].pop_front();
          total++;
          if (s_paddr !== mon_e.addr || s_pdata !== mon_e.data ||
              s_pstb !== mon_e.stb || s_pwrite !== mon_e.write) begin
            bad++;
            $display("FAIL mon_req m%0d: got a=%h d=%h s=%h w=%b want a=%h d=%h s=%h w=%b",
                     mon_idx, s_paddr, s_pdata, s_pstb, s_pwrite,
                     mon_e.addr, mon_e.data, mon_e.stb, mon_e.write);
          end
          total++;
          if (m_perr !== (mon_e.err ? m_pready : 2'b00) || m_prdata !== mon_e.rdata) begin
            bad++;
            $display("FAIL mon_resp m%0d: got perr=%b rdata=%h want err=%b rdata=%h",
                     mon_idx, m_perr, m_prdata, mon_e.err, mon_e.rdata);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- master helpers
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] stb, input logic w);
    exp_t e;
    m_paddr[i*AW +: AW] = a;
    m_pdata[i*DW +: DW] = d;
    m_pstb[i*4 +: 4]    = stb;
    m_pwrite[i]         = w;
    m_psel[i]           = 1'b1;
    m_penable[i]        = 1'b1;
    e.addr  = a;
    e.data  = d;
    e.stb   = stb;
    e.write = w;
    e.err   = err_val;
    e.rdata = rd_val;
    exp_q[i].push_back(e);
  endtask

  task automatic issue_gen(input int i);
    logic [31:0] s;
    seq[i]++;
    s = 32'(seq[i]);
    issue(i, 32'h1000 * (i + 1) + (s << 2), {16'hC0DE, 8'(i), s[7:0]}, s[3:0] | 4'h1, s[0]);
  endtask

  // Called at a negedge: completions seen now release or renew the masters
  // just after the next rising edge.
  task automatic advance();
    logic [NM-1:0] done;
    done = m_pready;
    @(posedge pclk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (done[i]) begin
        if (left[i] > 0) begin
          left[i]--;
          issue_gen(i);
        end else begin
          m_psel[i]    = 1'b0;
          m_penable[i] = 1'b0;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    @(negedge pclk);
    total++;
    if ({s_psel, s_penable} !== 2'b00) begin
      bad++;
      $display("FAIL reset_sel: got psel/penable=%b want 00", {s_psel, s_penable});
    end
    total++;
    if ({m_pready, m_perr} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_resp: got pready/perr=%b want 0000", {m_pready, m_perr});
    end
    total++;
    if (s_paddr !== '0 || s_pdata !== '0 || s_pstb !== '0 || s_pwrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got a=%h d=%h s=%h w=%b want all zero",
               s_paddr, s_pdata, s_pstb, s_pwrite);
    end
    advance();
  endtask

  task automatic test_single_read();
    logic [3:0] want;
    rd_val = 32'hDEAD_BEEF;
    left[0] = 0;
    issue(0, 32'h10, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      want = {(c >= 1 && c <= 3), (c >= 2 && c <= 3), (c == 3) ? 2'b01 : 2'b00};
      total++;
      if ({s_psel, s_penable, m_pready} !== want) begin
        bad++;
        $display("FAIL single_seq c%0d: got psel/pen/pready=%b want %b",
                 c, {s_psel, s_penable, m_pready}, want);
      end
      if (c == 3) begin
        total++;
        if (m_prdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL single_rdata: got %h want deadbeef", m_prdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_simultaneous();
    int t0 = -1;
    int t1 = -1;
    bit saw11 = 0;
    rst = 1'b1;
    @(posedge pclk);
    #1;
    rst = 1'b0;
    left[0] = 0;
    left[1] = 0;
    issue(0, 32'h200, 32'h1111_2222, 4'h3, 1'b1);
    issue(1, 32'h300, 32'h3333_4444, 4'hC, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        total++;
        if (s_paddr !== 32'h200 || s_pwrite !== 1'b1) begin
          bad++;
          $display("FAIL simul_first: got s_paddr=%h w=%b want 00000200 w=1", s_paddr, s_pwrite);
        end
      end
      if (m_pready === 2'b11) saw11 = 1;
      if (m_pready === 2'b01 && t0 < 0) t0 = c;
      if (m_pready === 2'b10 && t1 < 0) t1 = c;
      advance();
    end
    total++;
    if (t0 != 3 || t1 != 7) begin
      bad++;
      $display("FAIL simul_timing: got m0 done c%0d m1 done c%0d want c3 and c7", t0, t1);
    end
    total++;
    if (saw11) begin
      bad++;
      $display("FAIL simul_onehot: got m_pready=11 want never 11");
    end
  endtask

  task automatic test_alternating();
    int last_c = -1;
    grant_log.delete();
    left[0] = 3;
    left[1] = 3;
    issue_gen(0);
    issue_gen(1);
    for (int c = 0; c < 60; c++) begin
      @(negedge pclk);
      if (m_pready !== 2'b00) last_c = c;
      advance();
      if (grant_log.size() >= 8 && m_psel == 2'b00) break;
    end
    total++;
    if (grant_log.size() != 8) begin
      bad++;
      $display("FAIL alt_count: got %0d completions want 8", grant_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (grant_log[k] != k % 2) begin
          bad++;
          $display("FAIL alt_order #%0d: got m%0d want m%0d", k, grant_log[k], k % 2);
        end
      end
    end
    total++;
    if (last_c != 31) begin
      bad++;
      $display("FAIL alt_throughput: got last completion c%0d want c31", last_c);
    end
  endtask

  task automatic test_stall();
    logic [3:0] want;
    stall   = 5;
    rd_val  = 32'h0BAD_CAFE;
    left[1] = 1;
    issue_gen(1);
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (c < 10) begin
        want = {((c >= 1 && c <= 7) || c == 9), (c >= 2 && c <= 7),
                (c == 7) ? 2'b10 : 2'b00};
        total++;
        if ({s_psel, s_penable, m_pready} !== want) begin
          bad++;
          $display("FAIL stall_seq c%0d: got psel/pen/pready=%b want %b",
                   c, {s_psel, s_penable, m_pready}, want);
        end
      end
      advance();
    end
    stall = 1;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    left[0] = 0;
    left[1] = 0;
    issue(0, 32'h400, 32'h4, 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      advance();
    end
    // m0 just completed, so m1 holds priority for the contended request.
    stall = 3;
    issue(0, 32'h500, 32'h5, 4'hF, 1'b1);
    issue(1, 32'h600, 32'h6, 4'hF, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk);
      if (s_penable === 1'b1) begin
        found = 1;
        break;
      end
      advance();
    end
    total++;
    if (!found || s_paddr !== 32'h600) begin
      bad++;
      $display("FAIL rstmid_pre: got found=%0d s_paddr=%h want 1 and 00000600", found, s_paddr);
    end
    rst       = 1'b1;
    m_psel    = '0;
    m_penable = '0;
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge pclk);
    total++;
    if ({s_psel, s_penable, m_pready} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_outputs: got psel/pen/pready=%b want 0000",
               {s_psel, s_penable, m_pready});
    end
    rst = 1'b0;
    @(posedge pclk);
    #1;
    stall = 1;
    grant_log.delete();
    issue(0, 32'h700, 32'h7, 4'hF, 1'b0);
    issue(1, 32'h800, 32'h8, 4'hF, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        total++;
        if (s_paddr !== 32'h700) begin
          bad++;
          $display("FAIL rstmid_ptr: got s_paddr=%h want 00000700", s_paddr);
        end
      end
      advance();
    end
    total++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      bad++;
      $display("FAIL rstmid_after: got %0d completions want m0 then m1", grant_log.size());
    end
  endtask

  task automatic test_perr_capture();
    err_val = 1'b1;
    rd_val  = 32'h1234_5678;
    left[1] = 0;
    issue(1, 32'h4440, 32'h5555_AAAA, 4'h5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        m_paddr[AW +: AW] = 32'hFFFF_0000;
        m_pdata[DW +: DW] = 32'h0;
      end
      if (c == 2) begin
        total++;
        if (s_paddr !== 32'h4440 || s_pdata !== 32'h5555_AAAA) begin
          bad++;
          $display("FAIL perr_hold: got a=%h d=%h want 00004440 5555aaaa", s_paddr, s_pdata);
        end
        total++;
        if (m_perr !== 2'b00) begin
          bad++;
          $display("FAIL perr_early: got m_perr=%b want 00", m_perr);
        end
      end
      if (c == 3) begin
        total++;
        if ({m_pready, m_perr} !== 4'b1010) begin
          bad++;
          $display("FAIL perr_resp: got pready/perr=%b want 1010", {m_pready, m_perr});
        end
      end
      advance();
    end
    err_val = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    m_paddr   = '0;
    m_pdata   = '0;
    m_pstb    = '0;
    m_pwrite  = '0;
    m_psel    = '0;
    m_penable = '0;
    for (int i = 0; i < NM; i++) begin
      left[i] = 0;
      seq[i]  = 0;
    end
    test_reset();
    test_single_read();
    test_simultaneous();
    test_alternating();
    test_stall();
    test_reset_mid();
    test_perr_capture();
    total++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d uncompleted requests want 0",
               exp_q[0].size() + exp_q[1].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
